// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC / instruction fetch path.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          INST_WIDTH       = 32;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [INST_WIDTH-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: request -> wait for word -> hold for decoder,
// with PC redirects that can cancel an in-flight fetch.
module instr_fetch_unit
  import npc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_unit_if.master    mem,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [31:0]           fetch_count
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
  logic [31:0]           count_q, count_d;
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
  assign pc_plus4        = pc_q + ADDR_WIDTH'(4);

  // drop marks a fetch whose response must be thrown away because the PC moved under it
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    count_d     = count_q;
    req_valid   = 1'b0;

    case (state_q)
      ST_REQ: begin
        req_valid = 1'b1;
        if (redirect_valid) pc_d = redirect_target;
        if (mem.mem_req_ready) begin
          state_d = ST_WAIT;
          drop_d  = redirect_valid;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) pc_d = redirect_target;
        if (mem.mem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_inst_d  = mem.mem_rsp_data;
            state_d     = ST_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (out_ready) count_d = count_q + 32'd1;
        if (redirect_valid) begin
          pc_d        = redirect_target;
          out_valid_d = 1'b0;
          state_d     = ST_REQ;
        end else if (out_ready) begin
          pc_d        = pc_plus4;
          out_valid_d = 1'b0;
          state_d     = ST_REQ;
        end
      end

      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      count_q     <= count_d;
    end
  end

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = pc_q;
  assign out_valid         = out_valid_q;
  assign out_pc            = out_pc_q;
  assign out_inst          = out_inst_q;
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle table, reset-in-WAIT sequence, then random
// traffic checked against an instruction-stream reference model.
module tb_instr_fetch_unit;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] fetch_count;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(32)) mem_if ();

  instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem            (mem_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        ready;
    logic        rspValid;
    logic [31:0] rspData;
    logic        redir;
    logic [31:0] redirPc;
    logic        outReady;
    logic        eReqValid;
    logic [31:0] eAddr;
    logic        eOutValid;
    logic [31:0] eOutPc;
    logic [31:0] eOutInst;
    logic [31:0] eCount;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I0  = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0010_0093;
  localparam logic [31:0] I2  = 32'h0020_0113;
  localparam logic [31:0] I3  = 32'h0030_0193;
  localparam logic [31:0] I4  = 32'h0040_0213;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  // Contents of the imaginary instruction memory used by the random phase
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic rr, input logic [31:0] rp, input logic ordy,
                              input logic erv, input logic [31:0] ea, input logic eov,
                              input logic [31:0] epc, input logic [31:0] ei,
                              input logic [31:0] ec);
    vec_t v;
    v.ready = rdy; v.rspValid = rv; v.rspData = rd; v.redir = rr; v.redirPc = rp;
    v.outReady = ordy; v.eReqValid = erv; v.eAddr = ea; v.eOutValid = eov;
    v.eOutPc = epc; v.eOutInst = ei; v.eCount = ec;
    return v;
  endfunction

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic rr, input logic [31:0] rp, input logic ordy);
    mem_if.mem_req_ready = rdy;
    mem_if.mem_rsp_valid = rv;
    mem_if.mem_rsp_data  = rd;
    redirect_valid       = rr;
    redirect_pc          = rp;
    out_ready            = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input logic erv, input logic [31:0] ea, input logic eov,
                          input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ec);
    checkOutput("mem_req_valid", 32'(mem_if.mem_req_valid), 32'(erv));
    checkOutput("mem_req_addr", mem_if.mem_req_addr, ea);
    checkOutput("out_valid", 32'(out_valid), 32'(eov));
    checkOutput("out_pc", out_pc, epc);
    checkOutput("out_inst", out_inst, ei);
    checkOutput("fetch_count", fetch_count, ec);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    nFails++;
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

  initial begin
    logic [31:0] expPc;
    int          modelCnt;
    bit          pend;
    int          lat;
    logic [31:0] paddr;
    int          idle;
    logic        rdy, rv, rr, ordy;
    logic [31:0] rd, rp;

    // rdy rsp data  redir target  ordy | reqv addr  outv  out_pc  out_inst cnt
    vecs.push_back(mk(1,0,0,   0,0,            0, 1,32'h8000_0000,0,32'h0,0,0));
    vecs.push_back(mk(0,1,I0,  0,0,            0, 0,32'h8000_0000,0,32'h0,0,0));
    vecs.push_back(mk(0,0,0,   0,0,            1, 0,32'h8000_0000,1,32'h8000_0000,I0,0));
    vecs.push_back(mk(1,0,0,   0,0,            0, 1,32'h8000_0004,0,32'h8000_0000,I0,1));
    vecs.push_back(mk(0,1,I1,  0,0,            0, 0,32'h8000_0004,0,32'h8000_0000,I0,1));
    vecs.push_back(mk(0,0,0,   0,0,            1, 0,32'h8000_0004,1,32'h8000_0004,I1,1));
    vecs.push_back(mk(1,0,0,   0,0,            0, 1,32'h8000_0008,0,32'h8000_0004,I1,2));
    vecs.push_back(mk(0,1,I2,  0,0,            0, 0,32'h8000_0008,0,32'h8000_0004,I1,2));
    vecs.push_back(mk(1,1,BAD, 0,0,            0, 0,32'h8000_0008,1,32'h8000_0008,I2,2));
    vecs.push_back(mk(0,0,0,   0,0,            0, 0,32'h8000_0008,1,32'h8000_0008,I2,2));
    vecs.push_back(mk(0,0,0,   0,0,            0, 0,32'h8000_0008,1,32'h8000_0008,I2,2));
    vecs.push_back(mk(0,0,0,   0,0,            0, 0,32'h8000_0008,1,32'h8000_0008,I2,2));
    vecs.push_back(mk(0,0,0,   0,0,            1, 0,32'h8000_0008,1,32'h8000_0008,I2,2));
    vecs.push_back(mk(1,0,0,   0,0,            0, 1,32'h8000_000C,0,32'h8000_0008,I2,3));
    vecs.push_back(mk(0,0,0,   1,32'h8000_0102,0, 0,32'h8000_000C,0,32'h8000_0008,I2,3));
    vecs.push_back(mk(0,1,BAD, 0,0,            0, 0,32'h8000_0100,0,32'h8000_0008,I2,3));
    vecs.push_back(mk(1,0,0,   0,0,            0, 1,32'h8000_0100,0,32'h8000_0008,I2,3));
    vecs.push_back(mk(0,1,I3,  0,0,            0, 0,32'h8000_0100,0,32'h8000_0008,I2,3));
    vecs.push_back(mk(0,0,0,   1,32'h8000_1000,1, 0,32'h8000_0100,1,32'h8000_0100,I3,3));
    vecs.push_back(mk(0,0,0,   1,32'hFFFF_FFFF,0, 1,32'h8000_1000,0,32'h8000_0100,I3,4));
    vecs.push_back(mk(1,0,0,   0,0,            0, 1,32'hFFFF_FFFC,0,32'h8000_0100,I3,4));
    vecs.push_back(mk(0,1,I4,  0,0,            0, 0,32'hFFFF_FFFC,0,32'h8000_0100,I3,4));
    vecs.push_back(mk(0,0,0,   0,0,            1, 0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,I4,4));
    vecs.push_back(mk(1,0,0,   1,32'h8000_0200,0, 1,32'h0000_0000,0,32'hFFFF_FFFC,I4,5));
    vecs.push_back(mk(0,1,BAD, 0,0,            0, 0,32'h8000_0200,0,32'hFFFF_FFFC,I4,5));
    vecs.push_back(mk(1,0,0,   0,0,            0, 1,32'h8000_0200,0,32'hFFFF_FFFC,I4,5));
    vecs.push_back(mk(0,1,BAD, 1,32'h8000_0301,0, 0,32'h8000_0200,0,32'hFFFF_FFFC,I4,5));
    vecs.push_back(mk(0,0,0,   0,0,            0, 1,32'h8000_0300,0,32'hFFFF_FFFC,I4,5));

    $display("[TB] directed cycle table, %0d vectors", vecs.size());
    doReset();
    foreach (vecs[i]) begin
      checkAll(vecs[i].eReqValid, vecs[i].eAddr, vecs[i].eOutValid,
               vecs[i].eOutPc, vecs[i].eOutInst, vecs[i].eCount);
      applyStimulus(vecs[i].ready, vecs[i].rspValid, vecs[i].rspData,
                    vecs[i].redir, vecs[i].redirPc, vecs[i].outReady);
      @(negedge clk);
    end

    $display("[TB] reset asserted while waiting for a response");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("wait_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkAll(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, BAD, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkAll(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, I0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkAll(1'b0, 32'h8000_0000, 1'b1, 32'h8000_0000, I0, 32'h0);

    $display("[TB] random traffic against instruction-stream model");
    doReset();
    expPc = 32'h8000_0000;
    modelCnt = 0;
    pend = 1'b0;
    lat = 0;
    paddr = '0;
    idle = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      checkOutput("rand_fetch_count", fetch_count, 32'(modelCnt));

      rv = 1'b0;
      rd = $urandom;
      if (pend) begin
        if (lat <= 1) begin
          rv = 1'b1;
          rd = memWord(paddr);
          pend = 1'b0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        rv = 1'b1;
      end
      rdy  = ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 1) == 1;
      rr   = ($urandom_range(0, 19) == 0);
      rp   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;

      if (mem_if.mem_req_valid && rdy) begin
        checkOutput("rand_one_outstanding", 32'(pend), 32'd0);
        pend  = 1'b1;
        lat   = $urandom_range(1, 3);
        paddr = mem_if.mem_req_addr;
      end

      // Each delivered word follows the previous one, unless a redirect happened since
      if (out_valid && ordy) begin
        checkOutput("rand_out_pc", out_pc, expPc);
        checkOutput("rand_out_inst", out_inst, memWord(expPc));
        expPc = expPc + 32'd4;
        modelCnt++;
        idle = 0;
      end
      if (rr) expPc = rp & ~32'd3;

      idle++;
      if (idle > 200) begin
        checkOutput("rand_progress_cycles", 32'(idle), 32'd200);
        break;
      end

      applyStimulus(rdy, rv, rd, rr, rp, ordy);
      @(negedge clk);
    end
    checkOutput("rand_final_count", fetch_count, 32'(modelCnt));

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
